sort_host_sequencer: RTL and testbench
======================================

Name: sort_host_sequencer

Overview:
Host-facing sequencer for the 8-entry in-place selection sorter.
- Accepts N unsorted bytes over a valid/ready stream and writes them into sorter RAM through the init port.
- Starts the sort, waits for the sorter's done with a timeout guard, then snapshots the sorted RAM and streams it back out over a valid/ready stream.
- Sits between the host/UART-side logic and the sorter top.

Parameters:
N, 8, number of RAM entries (sorter depth); AW = $clog2(N)
W, 8, data width per entry
TIMEOUT_CYC, 1024, max cycles in WAIT before error; counter width $clog2(TIMEOUT_CYC+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
abort  in  1  synchronous abort; return to LOAD
in_valid  in  1  host input byte valid
in_ready  out  1  sequencer can accept input byte
in_data  in  W  unsorted byte
out_valid  out  1  sorted byte valid
out_ready  in  1  host accepts sorted byte
out_data  out  W  sorted byte
out_last  out  1  high with final (index N-1) byte
busy  out  1  high in every state except LOAD with load count 0
err  out  1  sticky timeout flag
init_mode  out  1  to sorter: RAM init write strobe
init_addr  out  AW  to sorter: init write address
init_data  out  W  to sorter: init write data
s  out  1  to sorter: start
done  in  1  from sorter: sort complete
RAM_out  in  W x N  from sorter: RAM contents, unpacked array [0:N-1]

Behaviour:
- Reset (reset=0, async): state=LOAD, counters=0, err=0. Outputs: in_ready=0 during reset, then 1; out_valid=0, out_last=0, out_data=0, init_mode=0, init_addr=0, init_data=0, s=0, busy=0.
- States: LOAD, START, WAIT, DRAIN, ERR.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: register init_mode=1, init_addr=cnt, init_data=in_data for exactly the next cycle; cnt++. Latency: handshake cycle T, write strobe at T+1.
  - init_mode is 0 on all non-write cycles.
  - On acceptance of beat N-1: in_ready drops the following cycle; go to START.
- START (1 cycle):
  - Entered the cycle the final init_mode strobe is driven; s=0 in this cycle, so write and start never overlap.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - s=1.
  - Timeout counter increments every cycle.
  - Completion is a done rising edge only (done && !done_q, done_q registered). A done held high from a previous run is ignored.
  - On edge: snapshot RAM_out into an internal N x W register the same cycle, s=0 next cycle, idx=0, go to DRAIN.
  - Counter == TIMEOUT_CYC-1 with no edge: set err=1, s=0, go to ERR. If the edge and the timeout fall in the same cycle, the edge wins.
- DRAIN:
  - out_valid=1, out_data=snap[idx], out_last=(idx==N-1).
  - out_data is stable while out_valid && !out_ready (AXI-style hold).
  - On handshake: idx++. On the handshake with out_last: out_valid=0 next cycle, cnt=0, go to LOAD.
  - Sorter RAM changes during DRAIN do not affect the output (snapshot).
- ERR:
  - All handshakes idle (in_ready=0, out_valid=0); busy=1.
  - Exit only by abort or reset. Abort clears err.
- abort:
  - In any state: next cycle state=LOAD, counters cleared, s=0, init_mode=0, out_valid=0. err cleared.
  - Sorter RAM contents are left as is; a partial load is overwritten by the next load.
  - abort has priority over every handshake in the same cycle; the beat is not consumed.
- Reset mid-operation: immediate return to reset values; any in-flight beat is dropped.
- Counters: cnt and idx are AW bits and never wrap. Terminal index N-1 is checked explicitly, valid for N = power of 2.

Decomposition:
- Package sort_pkg:
  - seq_state_t enum {LOAD, START, WAIT, DRAIN, ERR}
  - localparams N_ENT=8, DW=8, AW=$clog2(N_ENT)
  - word_t typedef logic [DW-1:0]
- Optional sub-module sort_snapshot_buf: N x W capture register with load enable and read index mux. Everything else stays in one FSM module.

Test Plan:
1. Load 05,03,07,01,08,02,06,04 with in_valid always high. Required: init_addr 0..7 with matching init_data, one strobe each. Then s=1. Model done rising 40 cycles later with RAM_out={01..08}. Required: out stream 01..08, out_last only on 08, then busy=0.
2. Out backpressure: out_ready toggles 1,0,0,1 pattern. Required: out_data held constant during stalls, exactly 8 beats, no duplicates or skips.
3. Sparse input: in_valid high every 3rd cycle. Required: exactly 8 init strobes, s not asserted until 1 cycle after the 8th strobe.
4. Stale done: done held 1 from the start of WAIT. Required: no completion until done goes 0 then 1. With TIMEOUT_CYC=16 and no edge: err=1 after 16 WAIT cycles, s=0, state ERR. abort then gives err=0 and in_ready=1 next cycle.
5. Abort after 4 beats loaded. Required: next load restarts at init_addr=0. Same-cycle abort + in_valid: the beat is not consumed.
6. Reset asserted mid-DRAIN at idx=3. Required: out_valid=0, s=0, init_mode=0 asynchronously. After release, in_ready=1 and busy=0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the selection-sorter host sequencer.
// State encodings, table sizes and the data word type.
package sort_pkg;

  localparam int N_ENT = 8;
  localparam int DW    = 8;
  localparam int AW    = $clog2(N_ENT);

  typedef logic [DW-1:0] word_t;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  typedef enum logic [2:0] {
    LOAD  = S_LOAD,
    START = S_START,
    WAIT  = S_WAIT,
    DRAIN = S_DRAIN,
    ERR   = S_ERR
  } seq_state_t;

endpackage

// File: rtl/sort_snapshot_buf.sv
// Capture register for the sorted RAM image.
// Loaded once per sort, read back by drain index.
module sort_snapshot_buf #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld,
  input  logic [W-1:0]         din [0:N-1],
  input  logic [$clog2(N)-1:0] idx,
  output logic [W-1:0]         dout
);

  logic [W-1:0] mem [0:N-1];

  // Capture the whole sorter RAM in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (ld) begin
      for (int i = 0; i < N; i++) mem[i] <= din[i];
    end
  end

  assign dout = mem[idx];

endmodule

// File: rtl/sort_host_sequencer.sv
// Host sequencer: load sorter RAM, start, wait, stream result.
// Sits between the host byte streams and the sorter top.
module sort_host_sequencer
  import sort_pkg::*;
#(
  parameter int N           = N_ENT,
  parameter int W           = DW,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err,
  output logic                 init_mode,
  output logic [$clog2(N)-1:0] init_addr,
  output logic [W-1:0]         init_data,
  output logic                 s,
  input  logic                 done,
  input  logic [W-1:0]         RAM_out [0:N-1]
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IW-1:0] LAST_IX = IW'(N - 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYC - 1);

  seq_state_t    state;
  logic [IW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo;
  logic          rdy_q;
  logic          done_q;
  logic          err_q;
  logic [W-1:0]  snap_q;

  logic in_hs;
  logic out_hs;
  logic done_rise;
  logic snap_ld;
  logic tmo_hit;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign done_rise = done && !done_q;
  assign tmo_hit   = (tmo == TMO_END);
  assign snap_ld   = (state == WAIT) && done_rise && !abort;

  assign in_ready  = rdy_q && (state == LOAD);
  assign s         = (state == WAIT);
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && (idx == LAST_IX);
  assign out_data  = out_valid ? snap_q : '0;
  assign busy      = !((state == LOAD) && (cnt == '0));
  assign err       = err_q;

  // Hold in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Delayed done so only a fresh rising edge completes a sort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= done;
  end

  // Main sequencing FSM; abort beats every handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      idx       <= '0;
      tmo       <= '0;
      err_q     <= 1'b0;
      init_mode <= 1'b0;
      init_addr <= '0;
      init_data <= '0;
    end else begin
      init_mode <= 1'b0;
      if (abort) begin
        state <= LOAD;
        cnt   <= '0;
        idx   <= '0;
        tmo   <= '0;
        err_q <= 1'b0;
      end else begin
        unique case (state)
          LOAD: begin
            if (in_hs) begin
              init_mode <= 1'b1;
              init_addr <= cnt;
              init_data <= in_data;
              if (cnt == LAST_IX) begin
                cnt   <= '0;
                state <= START;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          START: begin
            tmo   <= '0;
            state <= WAIT;
          end
          WAIT: begin
            tmo <= tmo + 1'b1;
            if (done_rise) begin
              idx   <= '0;
              state <= DRAIN;
            end else if (tmo_hit) begin
              err_q <= 1'b1;
              state <= ERR;
            end
          end
          DRAIN: begin
            if (out_hs) begin
              if (idx == LAST_IX) begin
                idx   <= '0;
                cnt   <= '0;
                state <= LOAD;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          ERR: begin
            state <= ERR;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

  sort_snapshot_buf #(
    .N (N),
    .W (W)
  ) u_snap (
    .clk   (clk),
    .reset (reset),
    .ld    (snap_ld),
    .din   (RAM_out),
    .idx   (idx),
    .dout  (snap_q)
  );

endmodule

// File: tb/tb_sort_host_sequencer.sv
// Directed bench for sort_host_sequencer.
// Second instance uses a short timeout for the error path.
module tb_sort_host_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       done;
  logic [7:0] ram [0:7];

  logic       in_ready, out_valid, out_last, busy, err;
  logic       init_mode, s;
  logic [2:0] init_addr;
  logic [7:0] out_data, init_data;

  logic       t_in_ready, t_out_valid, t_out_last, t_busy, t_err;
  logic       t_init_mode, t_s;
  logic [2:0] t_init_addr;
  logic [7:0] t_out_data, t_init_data;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] sorted;
  } vec_t;

  vec_t t1 [8];

  always #5 clk = ~clk;

  sort_host_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err),
    .init_mode (init_mode),
    .init_addr (init_addr),
    .init_data (init_data),
    .s         (s),
    .done      (done),
    .RAM_out   (ram)
  );

  sort_host_sequencer #(.TIMEOUT_CYC(16)) dut_t (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (t_in_ready),
    .in_data   (in_data),
    .out_valid (t_out_valid),
    .out_ready (out_ready),
    .out_data  (t_out_data),
    .out_last  (t_out_last),
    .busy      (t_busy),
    .err       (t_err),
    .init_mode (t_init_mode),
    .init_addr (t_init_addr),
    .init_data (t_init_data),
    .s         (t_s),
    .done      (done),
    .RAM_out   (ram)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] d [0:7], input int gap);
    int strobes;
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        step();
        if (init_mode) strobes++;
        chk("s_low_gap", s, 0);
      end
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d[k];
      step();
      in_valid = 1'b0;
      if (init_mode) strobes++;
      chk("init_mode", init_mode, 1);
      chk("init_addr", init_addr, k);
      chk("init_data", init_data, d[k]);
      chk("s_low_strobe", s, 0);
    end
    chk("in_ready_start", in_ready, 0);
    step();
    if (init_mode) strobes++;
    chk("s_wait", s, 1);
    chk("strobes", strobes, 8);
  endtask

  task automatic finish_sort(input logic [7:0] srt [0:7], input int dly);
    done = 1'b0;
    repeat (dly) step();
    chk("s_held", s, 1);
    chk("no_early_out", out_valid, 0);
    for (int i = 0; i < 8; i++) ram[i] = srt[i];
    done = 1'b1;
    step();
    chk("drain_valid", out_valid, 1);
    chk("s_off", s, 0);
  endtask

  task automatic drain(input logic [7:0] e [0:7], input bit bp,
                       input bit scr);
    int beats;
    bit held;
    logic [7:0] hd;
    beats = 0;
    held  = 1'b0;
    hd    = '0;
    for (int c = 0; c < 64 && beats < 8; c++) begin
      out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (held) chk("hold", out_data, hd);
      if (out_valid && out_ready) begin
        chk("out_data", out_data, e[beats]);
        chk("out_last", out_last, (beats == 7));
        beats++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        hd   = out_data;
      end
      if (scr) for (int i = 0; i < 8; i++) ram[i] = 8'hC0 + 8'(c + i);
      step();
    end
    out_ready = 1'b0;
    chk("beats", beats, 8);
    chk("drain_end_valid", out_valid, 0);
    chk("drain_end_busy", busy, 0);
    done = 1'b0;
  endtask

  initial begin
    logic [7:0] ld [0:7];
    logic [7:0] srt [0:7];
    logic [7:0] d2 [0:7];
    logic [7:0] s2 [0:7];
    logic [7:0] d3 [0:7];
    logic [7:0] s3 [0:7];

    t1[0] = '{8'h05, 8'h01}; t1[1] = '{8'h03, 8'h02};
    t1[2] = '{8'h07, 8'h03}; t1[3] = '{8'h01, 8'h04};
    t1[4] = '{8'h08, 8'h05}; t1[5] = '{8'h02, 8'h06};
    t1[6] = '{8'h06, 8'h07}; t1[7] = '{8'h04, 8'h08};
    d2 = '{8'h90, 8'h10, 8'h70, 8'h30, 8'h50, 8'h20, 8'h80, 8'h40};
    s2 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h70, 8'h80, 8'h90};
    d3 = '{8'hA3, 8'h1F, 8'h77, 8'h00, 8'hFF, 8'h42, 8'h05, 8'h99};
    s3 = '{8'h00, 8'h05, 8'h1F, 8'h42, 8'h77, 8'h99, 8'hA3, 8'hFF};

    reset = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; done = 1'b0;
    for (int i = 0; i < 8; i++) ram[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_init_mode", init_mode, 0);
    chk("rst_init_addr", init_addr, 0);
    chk("rst_s", s, 0);
    reset = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // dense load, sort done 40 cycles later
    for (int i = 0; i < 8; i++) begin
      ld[i]  = t1[i].din;
      srt[i] = t1[i].sorted;
    end
    load8(ld, 0);
    finish_sort(srt, 40);
    drain(srt, 1'b0, 1'b0);

    // backpressure with sorter RAM changing under the snapshot
    load8(d2, 0);
    finish_sort(s2, 5);
    drain(s2, 1'b1, 1'b1);

    // sparse input
    load8(d3, 2);
    finish_sort(s3, 3);
    drain(s3, 1'b0, 1'b0);

    // stale done and timeout
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    done = 1'b1;
    step();
    load8(ld, 0);
    chk("t_s_wait", t_s, 1);
    repeat (15) step();
    chk("t_s_before_tmo", t_s, 1);
    chk("t_err_before_tmo", t_err, 0);
    step();
    chk("t_err_set", t_err, 1);
    chk("t_s_err", t_s, 0);
    chk("t_in_ready_err", t_in_ready, 0);
    chk("t_out_valid_err", t_out_valid, 0);
    chk("t_busy_err", t_busy, 1);
    chk("stale_s", s, 1);
    chk("stale_no_out", out_valid, 0);
    done = 1'b0;
    step();
    for (int i = 0; i < 8; i++) ram[i] = srt[i];
    done = 1'b1;
    step();
    chk("fresh_edge", out_valid, 1);
    chk("t_err_sticky", t_err, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    done  = 1'b0;
    chk("t_err_clr", t_err, 0);
    chk("t_in_ready_abort", t_in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);

    // abort after 4 beats, abort beats a same-cycle input
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = d2[k];
      step();
      chk("part_addr", init_addr, k);
    end
    in_data = 8'hEE;
    abort   = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_no_strobe", init_mode, 0);
    chk("abort_cnt_clr", busy, 0);
    chk("abort_ready", in_ready, 1);
    load8(d3, 0);
    finish_sort(s3, 2);

    // reset mid-drain at idx 3
    out_ready = 1'b1;
    repeat (3) step();
    chk("mid_idx3", out_data, s3[3]);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_s", s, 0);
    chk("arst_init_mode", init_mode, 0);
    chk("arst_in_ready", in_ready, 0);
    out_ready = 1'b0;
    done = 1'b0;
    #2;
    reset = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
